// File: rtl/fb_rect_fill_pkg.sv
// Shared frame-buffer constants and state encoding for the rectangle writer and
// the scan-out path that reads the same 400x300 byte-per-pixel buffer.
package fb_rect_fill_pkg;

  localparam int FB_WIDTH         = 400;
  localparam int FB_HEIGHT        = 300;
  localparam int X_BITS           = 9;
  localparam int Y_BITS           = 9;
  localparam int BUFFER_ADDR_BITS = 17;
  localparam int CHANNEL_BITS     = 2;
  localparam int COLOR_BITS       = 3 * CHANNEL_BITS;
  localparam int PIXEL_BITS       = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } fb_state_e;

  // One colour byte replicated into every lane; byte enables pick the pixels.
  function automatic logic [31:0] color_word(input logic [COLOR_BITS-1:0] color);
    logic [PIXEL_BITS-1:0] px;
    px = {{(PIXEL_BITS - COLOR_BITS){1'b0}}, color};
    return {4{px}};
  endfunction

endpackage

// File: rtl/fb_lane_mask.sv
// Byte-enable mask for one write beat: n = min(4 - lane, remaining) pixels
// starting at byte lane `lane`.
module fb_lane_mask
  import fb_rect_fill_pkg::*;
(
  input  logic [1:0]      lane,
  input  logic [X_BITS:0] remaining,
  output logic [3:0]      we,
  output logic [2:0]      n
);

  logic [2:0] avail;
  logic [3:0] base;

  always_comb begin
    avail = 3'd4 - {1'b0, lane};
    if (remaining < {{(X_BITS - 2){1'b0}}, avail}) begin
      n = remaining[2:0];
    end else begin
      n = avail;
    end
    case (n)
      3'd1:    base = 4'b0001;
      3'd2:    base = 4'b0011;
      3'd3:    base = 4'b0111;
      3'd4:    base = 4'b1111;
      default: base = 4'b0000;
    endcase
    we = base << lane;
  end

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle-fill writer on port B of the frame buffer: clips the rectangle to
// the screen and writes up to four pixels per beat using byte enables.
module fb_rect_fill
  import fb_rect_fill_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [X_BITS-1:0]     cmd_x,
  input  logic [Y_BITS-1:0]     cmd_y,
  input  logic [X_BITS-1:0]     cmd_w,
  input  logic [Y_BITS-1:0]     cmd_h,
  input  logic [COLOR_BITS-1:0] cmd_color,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           buffer_addr,
  output logic [31:0]           buffer_din,
  input  logic [31:0]           buffer_dout,
  output logic                  buffer_en,
  output logic                  buffer_rst,
  output logic [3:0]            buffer_we
);

  localparam logic [X_BITS:0]           X_LIMIT    = (X_BITS + 1)'(FB_WIDTH);
  localparam logic [Y_BITS:0]           Y_LIMIT    = (Y_BITS + 1)'(FB_HEIGHT);
  localparam logic [BUFFER_ADDR_BITS-1:0] ROW_STRIDE = BUFFER_ADDR_BITS'(FB_WIDTH);

  fb_state_e                   state_q;
  logic [X_BITS-1:0]           x_q, w_q;
  logic [Y_BITS-1:0]           y_q, h_q;
  logic [COLOR_BITS-1:0]       color_q;
  logic [X_BITS:0]             x_end_q, cur_x_q;
  logic [Y_BITS:0]             y_end_q, row_q;
  logic [BUFFER_ADDR_BITS-1:0] row_base_q;
  logic                        last_q;
  logic                        busy_q, done_q, en_q;
  logic [BUFFER_ADDR_BITS-1:0] addr_q;
  logic [31:0]                 din_q;
  logic [3:0]                  we_q;

  logic [X_BITS:0]             setup_x_sum, setup_x_end;
  logic [Y_BITS:0]             setup_y_sum, setup_y_end;
  logic [BUFFER_ADDR_BITS-1:0] setup_row_base;
  logic                        setup_empty;
  logic [X_BITS:0]             src_cur_x, src_x_end, remaining, cur_x_d;
  logic [Y_BITS:0]             src_row, src_y_end, row_d;
  logic [BUFFER_ADDR_BITS-1:0] src_row_base, beat_addr;
  logic [3:0]                  lane_we;
  logic [2:0]                  lane_n;
  logic                        row_end, last_beat, issue;

  always_comb begin
    setup_x_sum    = {1'b0, x_q} + {1'b0, w_q};
    setup_y_sum    = {1'b0, y_q} + {1'b0, h_q};
    setup_x_end    = (setup_x_sum > X_LIMIT) ? X_LIMIT : setup_x_sum;
    setup_y_end    = (setup_y_sum > Y_LIMIT) ? Y_LIMIT : setup_y_sum;
    setup_row_base = {{(BUFFER_ADDR_BITS - Y_BITS){1'b0}}, y_q} * ROW_STRIDE;
    setup_empty    = (w_q == '0) || (h_q == '0) ||
                     ({1'b0, x_q} >= X_LIMIT) || ({1'b0, y_q} >= Y_LIMIT);

    // The first beat is issued out of SETUP, so its operands bypass the registers.
    if (state_q == ST_SETUP) begin
      src_cur_x    = {1'b0, x_q};
      src_x_end    = setup_x_end;
      src_row      = {1'b0, y_q};
      src_y_end    = setup_y_end;
      src_row_base = setup_row_base;
    end else begin
      src_cur_x    = cur_x_q;
      src_x_end    = x_end_q;
      src_row      = row_q;
      src_y_end    = y_end_q;
      src_row_base = row_base_q;
    end

    remaining = src_x_end - src_cur_x;
    beat_addr = src_row_base + {{(BUFFER_ADDR_BITS - X_BITS - 1){1'b0}}, src_cur_x};
    cur_x_d   = src_cur_x + {{(X_BITS - 2){1'b0}}, lane_n};
    row_d     = src_row + 1'b1;
    row_end   = (cur_x_d == src_x_end);
    last_beat = row_end && (row_d == src_y_end);
    issue     = ((state_q == ST_SETUP) && !setup_empty) ||
                ((state_q == ST_FILL) && !last_q);
  end

  fb_lane_mask u_lane_mask (
    .lane      (beat_addr[1:0]),
    .remaining (remaining),
    .we        (lane_we),
    .n         (lane_n)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      cur_x_q    <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      en_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      we_q       <= '0;
    end else begin
      done_q <= 1'b0;
      en_q   <= 1'b0;
      we_q   <= '0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            x_q     <= cmd_x;
            y_q     <= cmd_y;
            w_q     <= cmd_w;
            h_q     <= cmd_h;
            color_q <= cmd_color;
            busy_q  <= 1'b1;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          x_end_q <= setup_x_end;
          y_end_q <= setup_y_end;
          if (setup_empty) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (last_q) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (issue) begin
        addr_q <= beat_addr;
        din_q  <= color_word(color_q);
        en_q   <= 1'b1;
        we_q   <= lane_we;
        last_q <= last_beat;
        // Rows start word-aligned, so a beat never straddles a row boundary.
        if (row_end) begin
          cur_x_q    <= {1'b0, x_q};
          row_base_q <= src_row_base + ROW_STRIDE;
          row_q      <= row_d;
        end else begin
          cur_x_q    <= cur_x_d;
          row_base_q <= src_row_base;
          row_q      <= src_row;
        end
      end
    end
  end

  logic unused_dout;
  assign unused_dout = ^buffer_dout;

  assign cmd_ready   = resetn && (state_q == ST_IDLE);
  assign busy        = busy_q;
  assign done        = done_q;
  assign buffer_addr = {{(32 - BUFFER_ADDR_BITS){1'b0}}, addr_q};
  assign buffer_din  = din_q;
  assign buffer_en   = en_q;
  assign buffer_rst  = 1'b0;
  assign buffer_we   = we_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed, table-driven check of fb_rect_fill: beat addresses, byte enables,
// colour data, done/busy timing, clipping, empty rectangles and mid-fill reset.
module tb_fb_rect_fill;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_x, cmd_y, cmd_w, cmd_h;
  logic [5:0]  cmd_color;
  logic        busy, done;
  logic [31:0] buffer_addr, buffer_din, buffer_dout;
  logic        buffer_en, buffer_rst;
  logic [3:0]  buffer_we;

  always #5 clk = ~clk;

  fb_rect_fill dut (
    .clk         (clk),
    .resetn      (resetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_w       (cmd_w),
    .cmd_h       (cmd_h),
    .cmd_color   (cmd_color),
    .busy        (busy),
    .done        (done),
    .buffer_addr (buffer_addr),
    .buffer_din  (buffer_din),
    .buffer_dout (buffer_dout),
    .buffer_en   (buffer_en),
    .buffer_rst  (buffer_rst),
    .buffer_we   (buffer_we)
  );

  typedef struct packed {
    logic [8:0]        x, y, w, h;
    logic [5:0]        color;
    logic [2:0]        nbeats;
    logic [3:0][31:0]  addr;
    logic [3:0][3:0]   we;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vec [NVEC];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int x, input int y, input int w, input int h,
                              input int c, input int nb);
    vec_t v;
    v        = '0;
    v.x      = 9'(x);
    v.y      = 9'(y);
    v.w      = 9'(w);
    v.h      = 9'(h);
    v.color  = 6'(c);
    v.nbeats = 3'(nb);
    return v;
  endfunction

  task automatic beat(input int i, input int k, input int a, input logic [3:0] m);
    vec[i].addr[k] = 32'(a);
    vec[i].we[k]   = m;
  endtask

  // Run one command from the table; hold keeps cmd_valid asserted (with
  // different fields) while the command is in progress.
  task automatic run_cmd(input int i, input bit hold);
    logic [31:0] din_exp;
    logic [7:0]  px;
    px      = {2'b00, vec[i].color};
    din_exp = {px, px, px, px};
    @(negedge clk);
    check($sformatf("v%0d ready", i), 32'(cmd_ready), 32'd1);
    cmd_x     = vec[i].x;
    cmd_y     = vec[i].y;
    cmd_w     = vec[i].w;
    cmd_h     = vec[i].h;
    cmd_color = vec[i].color;
    cmd_valid = 1'b1;
    @(negedge clk);
    if (hold) begin
      cmd_x = 9'd0; cmd_y = 9'd0; cmd_w = 9'd1; cmd_h = 9'd1; cmd_color = 6'h3F;
    end else begin
      cmd_valid = 1'b0;
    end
    check($sformatf("v%0d setup busy", i), 32'(busy), 32'd1);
    check($sformatf("v%0d setup en", i), 32'(buffer_en), 32'd0);
    check($sformatf("v%0d setup ready", i), 32'(cmd_ready), 32'd0);
    for (int k = 0; k < int'(vec[i].nbeats); k++) begin
      @(negedge clk);
      check($sformatf("v%0d b%0d addr", i, k), buffer_addr, vec[i].addr[k]);
      check($sformatf("v%0d b%0d we", i, k), 32'(buffer_we), 32'(vec[i].we[k]));
      check($sformatf("v%0d b%0d en", i, k), 32'(buffer_en), 32'd1);
      check($sformatf("v%0d b%0d din", i, k), buffer_din, din_exp);
      check($sformatf("v%0d b%0d done", i, k), 32'(done), 32'd0);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check($sformatf("v%0d done", i), 32'(done), 32'd1);
    check($sformatf("v%0d done we", i), 32'(buffer_we), 32'd0);
    check($sformatf("v%0d done en", i), 32'(buffer_en), 32'd0);
    check($sformatf("v%0d done busy", i), 32'(busy), 32'd1);
    $display("cmd v%0d x=%0d y=%0d w=%0d h=%0d beats=%0d", i, vec[i].x, vec[i].y,
             vec[i].w, vec[i].h, vec[i].nbeats);
    @(negedge clk);
    check($sformatf("v%0d idle done", i), 32'(done), 32'd0);
    check($sformatf("v%0d idle busy", i), 32'(busy), 32'd0);
  endtask

  initial begin
    vec[0] = mk(0, 0, 8, 1, 'h2A, 2);     beat(0, 0, 0, 4'b1111); beat(0, 1, 4, 4'b1111);
    vec[1] = mk(3, 1, 6, 1, 'h15, 3);     beat(1, 0, 403, 4'b1000);
    beat(1, 1, 404, 4'b1111);             beat(1, 2, 408, 4'b0001);
    vec[2] = mk(0, 2, 4, 3, 'h3F, 3);     beat(2, 0, 800, 4'b1111);
    beat(2, 1, 1200, 4'b1111);            beat(2, 2, 1600, 4'b1111);
    vec[3] = mk(398, 299, 10, 10, 'h01, 1); beat(3, 0, 119998, 4'b1100);
    vec[4] = mk(5, 0, 2, 2, 'h0C, 2);     beat(4, 0, 5, 4'b0110); beat(4, 1, 405, 4'b0110);
    vec[5] = mk(10, 10, 0, 5, 'h05, 0);
    vec[6] = mk(400, 0, 4, 1, 'h05, 0);
    vec[7] = mk(0, 300, 4, 1, 'h05, 0);
    vec[8] = mk(0, 0, 4, 0, 'h05, 0);
    vec[9] = mk(396, 0, 4, 1, 'h30, 1);   beat(9, 0, 396, 4'b1111);

    resetn = 1'b0; cmd_valid = 1'b0; buffer_dout = 32'h0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    #1;
    check("rst ready", 32'(cmd_ready), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst en", 32'(buffer_en), 32'd0);
    check("rst we", 32'(buffer_we), 32'd0);
    check("rst addr", buffer_addr, 32'd0);
    check("rst din", buffer_din, 32'd0);
    check("rst bufrst", 32'(buffer_rst), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < NVEC; i++) run_cmd(i, 1'b0);

    // Valid held while busy must not produce a second acceptance.
    run_cmd(1, 1'b1);

    // Reset on the second beat of a three-row fill.
    @(negedge clk);
    cmd_x = vec[2].x; cmd_y = vec[2].y; cmd_w = vec[2].w; cmd_h = vec[2].h;
    cmd_color = vec[2].color; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("mid b0 addr", buffer_addr, 32'd800);
    @(negedge clk);
    check("mid b1 addr", buffer_addr, 32'd1200);
    resetn = 1'b0;
    #1;
    check("mid rst we", 32'(buffer_we), 32'd0);
    check("mid rst en", 32'(buffer_en), 32'd0);
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("post rst done c%0d", k), 32'(done), 32'd0);
      check($sformatf("post rst en c%0d", k), 32'(buffer_en), 32'd0);
      check($sformatf("post rst ready c%0d", k), 32'(cmd_ready), 32'd1);
    end
    $display("reset mid-fill sequence complete");
    run_cmd(2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
